// File: rtl/seq_gen.sv
// rtl/seq_gen.sv - framed serial transmitter: sync header, payload MSB first, optional even parity
module seq_gen #(
    parameter int                DATA_W    = 8,
    parameter int                HDR_W     = 4,
    parameter logic [HDR_W-1:0]  HEADER    = 4'b0110,
    parameter int                PARITY_EN = 1,
    parameter logic              IDLE_LVL  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              dout,
    output logic              busy,
    output logic              done
);

    localparam int MAX_W = (HDR_W > DATA_W) ? HDR_W : DATA_W;
    localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2,
        PAR  = 2'd3
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [DATA_W-1:0]  data_sh, data_sh_n;
    logic [HDR_W-1:0]   hdr_sh, hdr_sh_n;
    logic               par, par_n;
    logic               dout_n;
    logic               done_n;

    // Register the FSM, the shifters and the registered line outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            data_sh <= '0;
            hdr_sh  <= '0;
            par     <= 1'b0;
            dout    <= IDLE_LVL;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            data_sh <= data_sh_n;
            hdr_sh  <= hdr_sh_n;
            par     <= par_n;
            dout    <= dout_n;
            done    <= done_n;
        end
    end

    // Next-state logic: cnt counts the bits still to follow the one on dout in the current field
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        data_sh_n = data_sh;
        hdr_sh_n  = hdr_sh;
        par_n     = par;
        dout_n    = dout;
        done_n    = 1'b0;
        case (state)
            IDLE: begin
                dout_n = IDLE_LVL;
                if (tx_valid) begin
                    data_sh_n = tx_data;
                    par_n     = ^tx_data;
                    // The first header bit goes out on the accepting edge; keep the rest queued
                    dout_n    = HEADER[HDR_W-1];
                    hdr_sh_n  = HEADER << 1;
                    cnt_n     = CNT_W'(HDR_W - 1);
                    state_n   = HDR;
                end
            end
            HDR: begin
                if (cnt == '0) begin
                    dout_n    = data_sh[DATA_W-1];
                    data_sh_n = data_sh << 1;
                    cnt_n     = CNT_W'(DATA_W - 1);
                    state_n   = DATA;
                end else begin
                    dout_n   = hdr_sh[HDR_W-1];
                    hdr_sh_n = hdr_sh << 1;
                    cnt_n    = cnt - 1'b1;
                end
            end
            DATA: begin
                if (cnt == '0) begin
                    if (PARITY_EN != 0) begin
                        dout_n  = par;
                        state_n = PAR;
                    end else begin
                        dout_n  = IDLE_LVL;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end
                end else begin
                    dout_n    = data_sh[DATA_W-1];
                    data_sh_n = data_sh << 1;
                    cnt_n     = cnt - 1'b1;
                end
            end
            PAR: begin
                dout_n  = IDLE_LVL;
                done_n  = 1'b1;
                state_n = IDLE;
            end
            default: begin
                dout_n  = IDLE_LVL;
                state_n = IDLE;
            end
        endcase
    end

    assign tx_ready = (state == IDLE);
    assign busy     = ~tx_ready;

endmodule

// File: tb/tb_seq_gen.sv
// tb/tb_seq_gen.sv - randomized and directed bench for seq_gen against a frame-queue model
module tb_seq_gen;

    localparam int              DATA_W    = 8;
    localparam int              HDR_W     = 4;
    localparam logic [HDR_W-1:0] HEADER   = 4'b0110;
    localparam int              PARITY_EN = 1;
    localparam logic            IDLE_LVL  = 1'b1;
    localparam int              F         = HDR_W + DATA_W + PARITY_EN;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ready;
    logic              dout;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    seq_gen #(
        .DATA_W(DATA_W), .HDR_W(HDR_W), .HEADER(HEADER),
        .PARITY_EN(PARITY_EN), .IDLE_LVL(IDLE_LVL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .dout(dout), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: each accepted word becomes a list of per-cycle expected outputs
    typedef struct packed {
        logic d;
        logic dn;
        logic rdy;
    } ent_t;

    ent_t cur = '{d: IDLE_LVL, dn: 1'b0, rdy: 1'b1};
    ent_t q[$];

    function automatic logic frame_bit(input logic [DATA_W-1:0] w, input int i);
        if (i < HDR_W)
            return HEADER[HDR_W-1-i];
        else if (i < HDR_W + DATA_W)
            return w[DATA_W-1-(i-HDR_W)];
        else
            return logic'($countones(w) % 2);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            cur = '{d: IDLE_LVL, dn: 1'b0, rdy: 1'b1};
        end else if (cur.rdy && tx_valid) begin
            for (int i = 0; i < F; i++)
                q.push_back('{d: frame_bit(tx_data, i), dn: 1'b0, rdy: 1'b0});
            q.push_back('{d: IDLE_LVL, dn: 1'b1, rdy: 1'b1});
            cur = q.pop_front();
        end else if (q.size() > 0) begin
            cur = q.pop_front();
        end else begin
            cur = '{d: IDLE_LVL, dn: 1'b0, rdy: 1'b1};
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("dout", 32'(dout), 32'(cur.d));
            chk("done", 32'(done), 32'(cur.dn));
            chk("tx_ready", 32'(tx_ready), 32'(cur.rdy));
            chk("busy", 32'(busy), 32'(!cur.rdy));
        end
    end

    // Sends one word and records F+1 line samples; optional noise on inputs and reset injection
    task automatic run_frame(input logic [DATA_W-1:0] d, input bit noise, input int rst_at,
                             output logic [F:0] cap);
        cap = '0;
        tx_data  = d;
        tx_valid = 1'b1;
        for (int i = 0; i <= F; i++) begin
            @(negedge clk);
            cap[F-i] = dout;
            tx_valid = 1'b0;
            if (noise && i >= 2 && i < 10) begin
                tx_data  = 8'h3C;
                tx_valid = i[0];
            end
            if (i == rst_at + 1) begin
                chk("rst_dout", 32'(dout), 32'(IDLE_LVL));
                chk("rst_ready", 32'(tx_ready), 32'd1);
                chk("rst_done", 32'(done), 32'd0);
                rst_n = 1'b1;
            end
            if (i == rst_at) rst_n = 1'b0;
        end
    endtask

    initial begin
        logic [F:0] cap;
        int t1, t2, nd;
        logic prev_rdy;

        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        repeat (3) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        run_frame(8'hA5, 1'b0, -5, cap);
        chk("frame_a5", 32'(cap), 32'(14'b0110_10100101_0_1));
        run_frame(8'h07, 1'b0, -5, cap);
        chk("frame_07", 32'(cap), 32'(14'b0110_00000111_1_1));
        run_frame(8'hA5, 1'b1, -5, cap);
        chk("frame_busy_ignore", 32'(cap), 32'(14'b0110_10100101_0_1));
        repeat (3) @(negedge clk);

        // Back-to-back: valid held high, word changed after the first accept
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        t1 = -1; t2 = -1; nd = 0;
        prev_rdy = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) nd++;
            if (prev_rdy && !tx_ready) begin
                if (t1 < 0) begin
                    t1 = c;
                    tx_data = 8'h00;
                end else if (t2 < 0) begin
                    t2 = c;
                    tx_valid = 1'b0;
                end
            end
            prev_rdy = tx_ready;
        end
        tx_valid = 1'b0;
        chk("b2b_gap", 32'(t2 - t1), 32'd14);
        chk("b2b_done_count", 32'(nd), 32'd2);

        // Reset while payload bit 3 is on the line, then a clean frame
        run_frame(8'hA5, 1'b0, HDR_W + 3, cap);
        run_frame(8'h5A, 1'b0, -5, cap);
        chk("frame_5a_after_rst", 32'(cap), 32'(14'b0110_01011010_0_1));

        // Random traffic with occasional reset
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            tx_valid = ($urandom_range(2) == 0);
            tx_data  = DATA_W'($urandom);
            rst_n    = ($urandom_range(59) != 0);
        end
        rst_n    = 1'b1;
        tx_valid = 1'b0;
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_gen.md
# seq_gen

Serial framed-sequence transmitter: the generating end of the team's serial pattern-detection link. It accepts a parallel payload word through a valid/ready handshake and emits it on a single-bit line: a fixed sync header, the payload MSB first, then an optional even-parity bit. `dout` changes on the rising edge so that a downstream detector sampling on the falling edge sees stable mid-bit data. The block sits between the test/control logic that supplies words and the serial line that feeds the detector.

## Interface
- `DATA_W`, default 8: payload width in bits, ≥1.
- `HDR_W`, default 4: sync header width in bits, ≥1.
- `HEADER`, default 4'b0110: sync header, sent MSB first.
- `PARITY_EN`, default 1: 1 appends an even-parity bit over the payload; 0 sends no parity bit.
- `IDLE_LVL`, default 1'b1: line level when no frame is in progress.
- `clk`  input  1  clock; all state updates on posedge.
- `rst_n`  input  1  reset, synchronous, active-low.
- `tx_valid`  input  1  source has a word on `tx_data`.
- `tx_data`  input  DATA_W  payload word.
- `tx_ready`  output  1  block can accept a word; high exactly when the FSM is in IDLE.
- `dout`  output  1  registered serial line.
- `busy`  output  1  frame in progress; equals the inverse of `tx_ready`.
- `done`  output  1  one-cycle pulse, registered, marking frame completion.

## Operation
- FSM states:
  - IDLE: `dout`=IDLE_LVL.
  - HDR: header bits.
  - DATA: payload bits.
  - PAR: parity bit; state exists only if PARITY_EN=1.
- Accept occurs at a posedge where state==IDLE and `tx_valid`=1. On that edge:
  - `tx_data` is latched into the shift register.
  - Parity is computed as the XOR of all `tx_data` bits.
  - `dout` is set to HEADER[HDR_W-1].
  - The state moves to HDR and the bit counter is set to HDR_W-1.
- HDR: each edge drives the next header bit. After HEADER[0] has been driven, the next edge drives `tx_data[DATA_W-1]` and the state moves to DATA.
- DATA: each edge shifts out the next lower bit. After bit 0 has been driven, the next edge does one of the following:
  - PARITY_EN=1: drives the parity bit and moves to PAR.
  - PARITY_EN=0: returns to IDLE.
- PAR: the next edge returns to IDLE.
- Return to IDLE, on that same edge: `dout` is set to IDLE_LVL and `done` is set to 1 for exactly one cycle.
- `tx_valid` and `tx_data` are ignored outside IDLE. A latched word is unaffected if the source changes `tx_data` after the accept.
- The bit counter is sized to hold max(HDR_W, DATA_W)-1. It must never wrap into an extra bit.
- Reset, whether at startup or mid-frame, sets the following on the next edge:
  - state = IDLE
  - `dout` = IDLE_LVL
  - `done` = 0
  - `tx_ready` = 1, `busy` = 0
  - The shift register, counter and parity are cleared.
  - The frame in progress is aborted with no `done` pulse.
- Reset has priority over an accept on the same edge.

## Timing
- Frame length F = HDR_W + DATA_W + PARITY_EN bit-cycles. With the defaults, F = 13.
- If the accept happens at edge k:
  - Frame bit i (0-based) is on `dout` from edge k+i until edge k+i+1.
  - The state is IDLE from edge k+F, and `done` is high from edge k+F until edge k+F+1.
  - `tx_ready` rises after edge k+F.
  - The earliest next accept is at edge k+F+1.
- There is therefore always at least one IDLE_LVL bit between frames. Back-to-back frames have a period of F+1 cycles.
- Latency from accept to the first header bit on `dout` is 0 cycles after the accepting edge, i.e. `dout` is registered.
- `dout` is stable across the falling edge of every bit-cycle.

## Test plan
- **Reset idle:** hold `rst_n`=0 for 3 edges, then release with `tx_valid`=0 → `dout`=1, `tx_ready`=1, `busy`=0, `done`=0 on every cycle.
- **Single frame (defaults):** `tx_data`=8'hA5 with `tx_valid` pulsed for 1 cycle → `dout` = 0,1,1,0, 1,0,1,0,0,1,0,1, 0 (parity), then 1. `done` is high for exactly the single cycle after the parity bit. `tx_ready` is low for 13 cycles.
- **Odd parity word:** `tx_data`=8'h07 → payload 0,0,0,0,0,1,1,1 followed by parity bit 1.
- **Back-to-back:** `tx_valid` held at 1 with 8'hFF then 8'h00 → the second header starts exactly 14 cycles after the first. Exactly one IDLE bit (1) lies between the frames, and `done` pulses twice.
- **Ignore while busy:** change `tx_data` to 8'h3C and toggle `tx_valid` during a frame of 8'hA5 → the serialized bits are still those of 8'hA5, and no extra frame is sent.
- **Reset mid-frame:** assert `rst_n`=0 at payload bit 3 → on the next edge `dout`=1 and `tx_ready`=1, with no `done` pulse. A new 8'h5A after release is sent as a complete, correct frame.
